// File: rtl/chain_control_egr_reg_pkg.sv
// Shared word map, bus geometry and FSM encoding for the egress control split
// of the CSR output bus.
package chain_control_egr_reg_pkg;

  localparam int REG_W   = 2048;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = REG_W / WORD_W;

  localparam int WORD_REQ     = 0;
  localparam int WORD_DATA    = 1;
  localparam int WORD_LAT_EN  = 2;
  localparam int WORD_CLR     = 3;
  localparam int WORD_BUSY_TH = 4;

  localparam int BUSY_TH_W = 24;
  localparam int CNT_W     = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } egr_state_e;

  // Bit offset of word idx on the flat CSR bus.
  function automatic int word_base(input int idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/chain_control_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment, and the value sticks at all-ones instead of wrapping.
module chain_control_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/chain_control_egr_split_reg_out.sv
// Drives chain_control egress control from the CSR output bus: forward-table
// update handshake with timeout, level configuration, stats clear and counters.
module chain_control_egr_split_reg_out
  import chain_control_egr_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [REG_W-1:0]     reg_out,
  input  logic [N_WORDS-1:0]   reg_wr_en,
  output logic [WORD_W-1:0]    egr_forward_update_req,
  output logic [WORD_W-1:0]    egr_forward_update_req_data,
  output logic                 egr_forward_update_req_ap_vld,
  input  logic                 egr_forward_update_req_ap_ack,
  output logic                 egr_req_busy,
  output logic                 egr_latency_enable,
  output logic [BUSY_TH_W-1:0] egr_busy_threshold,
  output logic                 stat_egr_clear,
  output logic [CNT_W-1:0]     egr_forward_update_req_count,
  output logic [CNT_W-1:0]     egr_forward_update_drop_count,
  output logic [CNT_W-1:0]     egr_forward_update_timeout_count
);

  localparam int REQ_LO  = word_base(WORD_REQ);
  localparam int DATA_LO = word_base(WORD_DATA);
  localparam int LAT_LO  = word_base(WORD_LAT_EN);
  localparam int CLR_LO  = word_base(WORD_CLR);
  localparam int TH_LO   = word_base(WORD_BUSY_TH);

  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  egr_state_e           state_q, state_d;
  logic [WORD_W-1:0]    req_q, req_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 lat_en_q, lat_en_d;
  logic [BUSY_TH_W-1:0] busy_th_q, busy_th_d;
  logic                 clr_q, clr_d;

  logic wr_req;
  logic accept;
  logic timeout;
  logic drop;

  assign wr_req = reg_wr_en[WORD_REQ];

  // Request FSM; the word-1 snapshot is taken only on the word-0 trigger.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    to_cnt_d = to_cnt_q;
    accept   = 1'b0;
    timeout  = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          req_d    = reg_out[REQ_LO +: WORD_W];
          data_d   = reg_out[DATA_LO +: WORD_W];
          to_cnt_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        drop = wr_req;
        if (egr_forward_update_req_ap_ack) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lat_en_d  = lat_en_q;
    busy_th_d = busy_th_q;
    if (reg_wr_en[WORD_LAT_EN]) begin
      lat_en_d = reg_out[LAT_LO];
    end
    if (reg_wr_en[WORD_BUSY_TH]) begin
      busy_th_d = reg_out[TH_LO +: BUSY_TH_W];
    end
    clr_d = reg_wr_en[WORD_CLR] & reg_out[CLR_LO];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      data_q    <= '0;
      to_cnt_q  <= '0;
      lat_en_q  <= 1'b0;
      busy_th_q <= '0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      to_cnt_q  <= to_cnt_d;
      lat_en_q  <= lat_en_d;
      busy_th_q <= busy_th_d;
      clr_q     <= clr_d;
    end
  end

  chain_control_sat_counter #(.WIDTH(CNT_W)) u_req_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (accept),
    .clr   (clr_q),
    .q     (egr_forward_update_req_count)
  );

  chain_control_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (drop),
    .clr   (clr_q),
    .q     (egr_forward_update_drop_count)
  );

  chain_control_sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .inc   (timeout),
    .clr   (clr_q),
    .q     (egr_forward_update_timeout_count)
  );

  assign egr_forward_update_req        = req_q;
  assign egr_forward_update_req_data   = data_q;
  assign egr_forward_update_req_ap_vld = (state_q == REQ);
  assign egr_req_busy                  = (state_q == REQ);
  assign egr_latency_enable            = lat_en_q;
  assign egr_busy_threshold            = busy_th_q;
  assign stat_egr_clear                = clr_q;

  // Bus bits and strobes this block does not consume.
  logic unused_bits;
  assign unused_bits = ^{reg_out[REG_W-1:TH_LO+BUSY_TH_W],
                         reg_out[TH_LO-1:CLR_LO+1],
                         reg_out[CLR_LO-1:LAT_LO+1],
                         reg_wr_en[N_WORDS-1:WORD_BUSY_TH+1],
                         reg_wr_en[WORD_DATA]};

endmodule
